// File: rtl/updown_counter.sv
// updown_counter: synchronous up/down counter with parallel load, programmable
// modulus and cascade outputs (tc/carry). Q always stays within 0..MODULUS-1.
// Legal parameter ranges: WIDTH 1..16, MODULUS 2..2^WIDTH.
module updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             _clear,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  input  logic             enable,
  input  logic             up,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] _Q,
  output logic             tc,
  output logic             carry,
  output logic             wrapped
);

  // Next-state arithmetic runs one bit wider than the counter, so that
  // MODULUS = 2^WIDTH is representable and the wrap compare stays exact.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS-1);

  logic [WIDTH-1:0] r_q;
  logic             r_wrapped;

  logic [WIDTH:0]   w_d_ext;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;
  logic [WIDTH-1:0] w_q_next;
  logic             w_wrapped_next;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_d_ext   = {1'b0, D};
  assign w_inc     = {1'b0, r_q} + ONE_EXT;
  assign w_dec     = {1'b0, r_q} - ONE_EXT;
  assign w_at_max  = (r_q == MAX_Q);
  assign w_at_zero = (r_q == '0);

  // Next-state selection: load beats count, count beats hold.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned, which would infer a latch.
    w_q_next       = r_q;
    w_wrapped_next = r_wrapped;
    if (load) begin
      // Out-of-range load data is replaced by 0 so Q never leaves the modulus.
      w_q_next       = (w_d_ext < MOD_EXT) ? D : '0;
      w_wrapped_next = 1'b0;
    end else if (enable) begin
      if (up) begin
        if (w_inc == MOD_EXT) begin
          w_q_next       = '0;
          w_wrapped_next = 1'b1;
        end else begin
          w_q_next = w_inc[WIDTH-1:0];
        end
      end else begin
        // Borrow out of the extended subtract means Q was 0.
        if (w_dec[WIDTH]) begin
          w_q_next       = MAX_Q;
          w_wrapped_next = 1'b1;
        end else begin
          w_q_next = w_dec[WIDTH-1:0];
        end
      end
    end
  end

  // State register: count value and sticky wrap flag, cleared asynchronously.
  always_ff @(posedge clk or negedge _clear) begin
    if (!_clear) begin
      r_q       <= '0;
      r_wrapped <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      r_q       <= w_q_next;
      r_wrapped <= w_wrapped_next;
    end
  end

  // Outputs: complement and cascade terms are purely combinational from Q.
  assign Q       = r_q;
  assign _Q      = ~r_q;
  assign wrapped = r_wrapped;
  assign tc      = up ? w_at_max : w_at_zero;
  assign carry   = tc & enable;

endmodule

// File: tb/tb_updown_counter.sv
// Testbench for updown_counter: decade, binary and two-stage cascade instances;
// table vectors, hand sequences for reset/wrap/cascade, random run vs model.
module tb_updown_counter;

  localparam int DEC_MOD = 10;

  logic clk;
  int   n_pass;
  int   n_total;

  // Decade instance (WIDTH=4, MODULUS=10)
  logic       d_clear, d_load, d_en, d_up;
  logic [3:0] d_d, d_q, d_qn;
  logic       d_tc, d_carry, d_wr;

  // Binary instance (WIDTH=4, MODULUS=16)
  logic       b_clear, b_load, b_en, b_up;
  logic [3:0] b_d, b_q, b_qn;
  logic       b_tc, b_carry, b_wr;

  // Two-stage decade cascade
  logic       c_clear, c_en;
  logic [3:0] c_lo_q, c_lo_qn, c_hi_q, c_hi_qn;
  logic       c_lo_tc, c_lo_carry, c_lo_wr;
  logic       c_hi_tc, c_hi_carry, c_hi_wr;

  updown_counter #(.WIDTH(4), .MODULUS(10)) u_dec (
    .clk(clk), ._clear(d_clear), .load(d_load), .D(d_d), .enable(d_en), .up(d_up),
    .Q(d_q), ._Q(d_qn), .tc(d_tc), .carry(d_carry), .wrapped(d_wr)
  );

  updown_counter #(.WIDTH(4), .MODULUS(16)) u_bin (
    .clk(clk), ._clear(b_clear), .load(b_load), .D(b_d), .enable(b_en), .up(b_up),
    .Q(b_q), ._Q(b_qn), .tc(b_tc), .carry(b_carry), .wrapped(b_wr)
  );

  updown_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .clk(clk), ._clear(c_clear), .load(1'b0), .D(4'd0), .enable(c_en), .up(1'b1),
    .Q(c_lo_q), ._Q(c_lo_qn), .tc(c_lo_tc), .carry(c_lo_carry), .wrapped(c_lo_wr)
  );

  updown_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .clk(clk), ._clear(c_clear), .load(1'b0), .D(4'd0), .enable(c_lo_carry), .up(1'b1),
    .Q(c_hi_q), ._Q(c_hi_qn), .tc(c_hi_tc), .carry(c_hi_carry), .wrapped(c_hi_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       ld;
    logic [3:0] d;
    logic       en;
    logic       up;
    int         q;
    logic       wr;
    logic       tc;
  } vec_t;

  vec_t vecs[12];

  // Random-run reference model state
  int m_q;
  int m_w;

  initial begin
    n_pass  = 0;
    n_total = 0;
    d_clear = 1'b0; d_load = 1'b0; d_d = 4'd0; d_en = 1'b1; d_up = 1'b0;
    b_clear = 1'b0; b_load = 1'b0; b_d = 4'd0; b_en = 1'b0; b_up = 1'b1;
    c_clear = 1'b0; c_en = 1'b0;

    // ---- Reset state (clear held low) ----
    #2;
    check("rst_q", int'(d_q), 0);
    check("rst_qn", int'(d_qn), 15);
    check("rst_wr", int'(d_wr), 0);
    check("rst_tc_down", int'(d_tc), 1);
    check("rst_carry_down", int'(d_carry), 1);
    d_up = 1'b1;
    #1;
    check("rst_tc_up", int'(d_tc), 0);
    check("rst_carry_up", int'(d_carry), 0);

    #9; // t=12, away from edges
    d_clear = 1'b1; b_clear = 1'b1; c_clear = 1'b1;
    d_en = 1'b1; d_up = 1'b1;

    // ---- Decade up-count, 12 edges from 0 ----
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("up_q[%0d]", i), int'(d_q), i % 10);
      check($sformatf("up_tc[%0d]", i), int'(d_tc), int'((i % 10) == 9));
      check($sformatf("up_wr[%0d]", i), int'(d_wr), int'(i >= 10));
    end

    // ---- Async clear mid-count (Q=7, wrapped set) ----
    for (int i = 0; i < 5; i++) tick();
    check("pre_clr_q", int'(d_q), 7);
    check("pre_clr_wr", int'(d_wr), 1);
    #3;
    d_clear = 1'b0;
    d_up = 1'b0;
    #1;
    check("clr_q", int'(d_q), 0);
    check("clr_qn", int'(d_qn), 15);
    check("clr_wr", int'(d_wr), 0);
    check("clr_tc", int'(d_tc), 1);
    tick();
    check("clr_held_q", int'(d_q), 0);
    d_clear = 1'b1;
    d_up = 1'b1;
    tick();
    check("post_clr_first_edge", int'(d_q), 1);

    // ---- Table vectors: load rules, down wrap, hold ----
    vecs[0]  = '{1'b1, 4'd2,  1'b0, 1'b0, 2, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'd0,  1'b1, 1'b0, 0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 4'd0,  1'b1, 1'b0, 9, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 4'd0,  1'b1, 1'b0, 8, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 4'd12, 1'b0, 1'b1, 0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 4'd9,  1'b1, 1'b1, 9, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 4'd0,  1'b0, 1'b1, 9, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 4'd3,  1'b0, 1'b1, 9, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 4'd0,  1'b0, 1'b0, 9, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'd0,  1'b1, 1'b1, 0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 4'd15, 1'b1, 1'b0, 0, 1'b0, 1'b1};
    for (int i = 0; i < 12; i++) begin
      d_load = vecs[i].ld;
      d_d    = vecs[i].d;
      d_en   = vecs[i].en;
      d_up   = vecs[i].up;
      tick();
      check($sformatf("vec_q[%0d]", i), int'(d_q), vecs[i].q);
      check($sformatf("vec_qn[%0d]", i), int'(d_qn), 15 - vecs[i].q);
      check($sformatf("vec_wr[%0d]", i), int'(d_wr), int'(vecs[i].wr));
      check($sformatf("vec_tc[%0d]", i), int'(d_tc), int'(vecs[i].tc));
      check($sformatf("vec_carry[%0d]", i), int'(d_carry), int'(vecs[i].tc & vecs[i].en));
    end
    d_load = 1'b0;

    // ---- Binary wrap at MODULUS = 2^WIDTH ----
    b_load = 1'b1; b_d = 4'd15; b_en = 1'b0; b_up = 1'b1;
    tick();
    check("bin_load_q", int'(b_q), 15);
    check("bin_tc", int'(b_tc), 1);
    check("bin_wr0", int'(b_wr), 0);
    b_load = 1'b0; b_en = 1'b1;
    tick();
    check("bin_wrap_q", int'(b_q), 0);
    check("bin_wrap_wr", int'(b_wr), 1);
    check("bin_wrap_qn", int'(b_qn), 15);

    // ---- Cascade: 100 edges from 00 ----
    c_clear = 1'b0;
    #1;
    c_clear = 1'b1;
    c_en = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      check($sformatf("casc_val[%0d]", i), int'(c_hi_q) * 10 + int'(c_lo_q), i % 100);
      check($sformatf("casc_hi_wr[%0d]", i), int'(c_hi_wr), int'(i >= 100));
    end
    c_en = 1'b0;

    // ---- Random run on the decade instance vs model ----
    d_clear = 1'b0;
    #1;
    d_clear = 1'b1;
    m_q = 0;
    m_w = 0;
    for (int i = 0; i < 300; i++) begin
      int nq;
      d_load = ($urandom_range(0, 7) == 0);
      d_d    = 4'($urandom_range(0, 15));
      d_en   = ($urandom_range(0, 3) != 0);
      d_up   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) begin
        #2;
        d_clear = 1'b0;
        #1;
        check($sformatf("rnd_clr_q[%0d]", i), int'(d_q), 0);
        check($sformatf("rnd_clr_wr[%0d]", i), int'(d_wr), 0);
        m_q = 0;
        m_w = 0;
        d_clear = 1'b1;
      end
      tick();
      if (d_load) begin
        m_q = (int'(d_d) < DEC_MOD) ? int'(d_d) : 0;
        m_w = 0;
      end else if (d_en) begin
        nq = d_up ? m_q + 1 : m_q - 1;
        if (nq < 0 || nq >= DEC_MOD) m_w = 1;
        m_q = (nq + DEC_MOD) % DEC_MOD;
      end
      check($sformatf("rnd_q[%0d]", i), int'(d_q), m_q);
      check($sformatf("rnd_qn[%0d]", i), int'(d_qn), 15 - m_q);
      check($sformatf("rnd_wr[%0d]", i), int'(d_wr), m_w);
      check($sformatf("rnd_tc[%0d]", i), int'(d_tc),
            int'(d_up ? (m_q == DEC_MOD - 1) : (m_q == 0)));
      check($sformatf("rnd_carry[%0d]", i), int'(d_carry),
            int'(d_en && (d_up ? (m_q == DEC_MOD - 1) : (m_q == 0))));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
